// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC request scheduler.
// Angles are unsigned degrees scaled by 2^16; results are signed Q16.
package cordic_pkg;

    localparam int ANG_W    = 25;
    localparam int PE_ANG_W = 23;

    localparam logic [ANG_W-1:0] D90  = 25'd5898240;
    localparam logic [ANG_W-1:0] D180 = 25'd11796480;
    localparam logic [ANG_W-1:0] D270 = 25'd17694720;
    localparam logic [ANG_W-1:0] D360 = 25'd23592960;

    localparam logic [31:0] Q16_ONE = 32'd65536;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/cordic_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searching upward from
// the slot after the last winner; the pointer moves only when a grant is taken.
module cordic_rr_arb #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            take,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);

    logic [ID_W-1:0] ptr;

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

    // Reset to N-1 so requester 0 is the first candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_W'(N - 1);
        end else if (take && gnt_any) begin
            ptr <= gnt_id;
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Shares one first-quadrant sin/cos CORDIC engine between N requesters:
// folds full-circle angles, runs the engine handshake, restores quadrant signs.
//
// state | meaning
// IDLE  | arbitrate; ack winner, latch id/quadrant/folded angle
// ISSUE | one-cycle pe_vld to the engine
// WAIT  | wait for pe_done, bounded by TIMEOUT cycles
// CAPT  | engine results sampled at the end of this cycle and unfolded
// RESP  | one-cycle rsp_vld with registered id/sin/cos/err
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int N       = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req,
    input  logic [N*ANG_W-1:0]    req_angle,
    output logic [N-1:0]          req_ack,
    output logic                  rsp_vld,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_sin,
    output logic [31:0]           rsp_cos,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  pe_vld,
    output logic [PE_ANG_W-1:0]   pe_angle,
    input  logic [31:0]           pe_sin,
    input  logic [31:0]           pe_cos,
    input  logic                  pe_done
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t state, state_nxt;

    logic [N-1:0]          gnt;
    logic [ID_W-1:0]       gnt_id;
    logic                  gnt_any;

    logic [ANG_W-1:0]      in_ang;
    logic [1:0]            in_quad;
    logic [PE_ANG_W-1:0]   in_fold;
    logic                  in_bad;

    logic [ID_W-1:0]       job_id;
    logic [1:0]            job_quad;
    logic [PE_ANG_W-1:0]   job_ang;
    logic [CNT_W-1:0]      wait_cnt;

    logic [31:0]           unf_sin;
    logic [31:0]           unf_cos;

    cordic_rr_arb #(
        .N    (N),
        .ID_W (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .take    (state == ST_IDLE),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    always_comb begin
        in_ang  = req_angle[int'(gnt_id)*ANG_W +: ANG_W];
        in_bad  = (in_ang >= D360);
        in_quad = 2'd0;
        in_fold = in_ang[PE_ANG_W-1:0];
        if (in_ang >= D270) begin
            in_quad = 2'd3;
            in_fold = PE_ANG_W'(in_ang - D270);
        end else if (in_ang >= D180) begin
            in_quad = 2'd2;
            in_fold = PE_ANG_W'(in_ang - D180);
        end else if (in_ang >= D90) begin
            in_quad = 2'd1;
            in_fold = PE_ANG_W'(in_ang - D90);
        end
    end

    always_comb begin
        unf_sin = pe_sin;
        unf_cos = pe_cos;
        unique case (job_quad)
            2'd0: begin unf_sin = pe_sin;  unf_cos = pe_cos;  end
            2'd1: begin unf_sin = pe_cos;  unf_cos = -pe_sin; end
            2'd2: begin unf_sin = -pe_sin; unf_cos = -pe_cos; end
            2'd3: begin unf_sin = -pe_cos; unf_cos = pe_sin;  end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        // rst_n gate keeps ack low while reset is held even if req is high.
        req_ack   = (state == ST_IDLE && rst_n) ? gnt : '0;
        pe_vld    = (state == ST_ISSUE);
        rsp_vld   = (state == ST_RESP);
        busy      = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (gnt_any) state_nxt = in_bad ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (pe_done)            state_nxt = ST_CAPT;
                else if (wait_cnt == '0) state_nxt = ST_RESP;
            end
            ST_CAPT: state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // pe_angle comes straight from job_ang, so it is stable for the whole job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_id   <= '0;
            job_quad <= '0;
            job_ang  <= '0;
            wait_cnt <= '0;
            rsp_id   <= '0;
            rsp_sin  <= '0;
            rsp_cos  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        job_id   <= gnt_id;
                        job_quad <= in_quad;
                        job_ang  <= in_bad ? '0 : in_fold;
                        if (in_bad) begin
                            rsp_id  <= gnt_id;
                            rsp_sin <= '0;
                            rsp_cos <= '0;
                            rsp_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: wait_cnt <= CNT_W'(TIMEOUT - 1);
                ST_WAIT: begin
                    if (!pe_done) begin
                        if (wait_cnt == '0) begin
                            rsp_id  <= job_id;
                            rsp_sin <= '0;
                            rsp_cos <= '0;
                            rsp_err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - 1'b1;
                        end
                    end
                end
                ST_CAPT: begin
                    rsp_id  <= job_id;
                    rsp_sin <= unf_sin;
                    rsp_cos <= unf_cos;
                    rsp_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign pe_angle = job_ang;

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched with a behavioural engine model and a
// response scoreboard filled at each ack.
`timescale 1ns/1ps
module tb_cordic_sched;
    import cordic_pkg::*;

    localparam int N       = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req = '0;
    logic [N*ANG_W-1:0]   req_angle = '0;
    logic [N-1:0]         req_ack;
    logic                 rsp_vld;
    logic [ID_W-1:0]      rsp_id;
    logic [31:0]          rsp_sin;
    logic [31:0]          rsp_cos;
    logic                 rsp_err;
    logic                 busy;
    logic                 pe_vld;
    logic [PE_ANG_W-1:0]  pe_angle;
    logic [31:0]          pe_sin = '0;
    logic [31:0]          pe_cos = '0;
    logic                 pe_done = 1'b0;

    always #5 clk = ~clk;

    cordic_sched #(.N(N), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_angle (req_angle),
        .req_ack   (req_ack),
        .rsp_vld   (rsp_vld),
        .rsp_id    (rsp_id),
        .rsp_sin   (rsp_sin),
        .rsp_cos   (rsp_cos),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .pe_vld    (pe_vld),
        .pe_angle  (pe_angle),
        .pe_sin    (pe_sin),
        .pe_cos    (pe_cos),
        .pe_done   (pe_done)
    );

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     s;
        logic [31:0]     c;
        logic            err;
    } exp_t;

    exp_t                exp_q[$];
    logic [PE_ANG_W-1:0] pe_q[$];
    int                  ack_log[$];
    exp_t                mon_e;

    int total = 0, bad = 0, cyc = 0;
    int eng_lat = 3, eng_cnt = 0;
    bit eng_mute = 0, spur = 0;
    int vld_cnt = 0, rsp_cnt = 0, onehot_bad = 0, ang_bad = 0;
    int last_ack_cyc = 0, last_vld_cyc = 0, last_done_cyc = 0, last_rsp_cyc = 0;
    bit in_job = 0, done_seen = 0;
    logic [PE_ANG_W-1:0] job_ang = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int id, input logic [ANG_W-1:0] ang);
        exp_t e;
        int   q;
        e.id  = ID_W'(id);
        e.s   = '0;
        e.c   = '0;
        e.err = 1'b1;
        if (int'(ang) < 23592960 && !eng_mute) begin
            q     = int'(ang) / 5898240;
            e.err = 1'b0;
            case (q)
                0:       begin e.s = pe_sin;  e.c = pe_cos;  end
                1:       begin e.s = pe_cos;  e.c = -pe_sin; end
                2:       begin e.s = -pe_sin; e.c = -pe_cos; end
                default: begin e.s = -pe_cos; e.c = pe_sin;  end
            endcase
        end
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Ack and response monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ack != '0) begin
                int id;
                logic [ANG_W-1:0] ang;
                id = 0;
                if ($countones(req_ack) != 1) onehot_bad++;
                for (int i = 0; i < N; i++) if (req_ack[i]) id = i;
                ang = req_angle[id*ANG_W +: ANG_W];
                ack_log.push_back(id);
                last_ack_cyc = cyc;
                exp_q.push_back(model(id, ang));
                if (int'(ang) < 23592960)
                    pe_q.push_back(PE_ANG_W'(int'(ang) - (int'(ang) / 5898240) * 5898240));
            end
            if (rsp_vld) begin
                last_rsp_cyc = cyc;
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_id",  rsp_id,  mon_e.id);
                    chk("rsp_sin", rsp_sin, mon_e.s);
                    chk("rsp_cos", rsp_cos, mon_e.c);
                    chk("rsp_err", rsp_err, mon_e.err);
                end
            end
        end
    end

    // Engine model: done pulses eng_lat cycles after pe_vld unless muted.
    always @(negedge clk) begin
        if (!rst_n) begin
            eng_cnt = 0;
            pe_done = 1'b0;
            in_job  = 0;
        end else begin
            if (in_job && !done_seen && !rsp_vld && pe_angle !== job_ang) ang_bad++;
            pe_done = spur;
            if (pe_vld) begin
                vld_cnt++;
                last_vld_cyc = cyc;
                job_ang   = pe_angle;
                in_job    = 1;
                done_seen = 0;
                if (pe_q.size() == 0) chk("pe_vld_unexpected", 1, 0);
                else                  chk("pe_angle", pe_angle, pe_q.pop_front());
                eng_cnt = eng_lat;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0 && !eng_mute) begin
                    pe_done       = 1'b1;
                    done_seen     = 1;
                    last_done_cyc = cyc;
                end
            end
            if (rsp_vld) in_job = 0;
        end
    end

    task automatic chk_zero(input string p);
        chk({p, "_req_ack"},  req_ack,  0);
        chk({p, "_rsp_vld"},  rsp_vld,  0);
        chk({p, "_rsp_id"},   rsp_id,   0);
        chk({p, "_rsp_sin"},  rsp_sin,  0);
        chk({p, "_rsp_cos"},  rsp_cos,  0);
        chk({p, "_rsp_err"},  rsp_err,  0);
        chk({p, "_busy"},     busy,     0);
        chk({p, "_pe_vld"},   pe_vld,   0);
        chk({p, "_pe_angle"}, pe_angle, 0);
    endtask

    task automatic run_job(input int i, input logic [ANG_W-1:0] ang);
        int  base, t;
        bit  got;
        base = rsp_cnt;
        got  = 0;
        @(posedge clk); #1;
        req_angle[i*ANG_W +: ANG_W] = ang;
        req[i] = 1'b1;
        for (t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ack[i]) got = 1;
        end
        if (!got) chk("ack_wait", 0, 1);
        @(posedge clk); #1;
        req[i] = 1'b0;
        t = 0;
        while (rsp_cnt == base && t < 100) begin @(negedge clk); #1; t++; end
        if (rsp_cnt == base) chk("rsp_wait", 0, 1);
    endtask

    task automatic hold_acks(input logic [N-1:0] mask, input int n);
        int a0, b, t;
        a0 = ack_log.size();
        b  = rsp_cnt;
        @(posedge clk); #1;
        req = mask;
        t = 0;
        while (ack_log.size() < a0 + n && t < 400) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        req = '0;
        if (ack_log.size() < a0 + n) chk("hold_ack_wait", 0, 1);
        t = 0;
        while (rsp_cnt < b + n && t < 400) begin @(negedge clk); #1; t++; end
        if (rsp_cnt < b + n) chk("hold_rsp_wait", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, v, b, t;
        bit got;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 30 deg, quadrant 0, with latency checks
        pe_sin = 32'd32768; pe_cos = 32'd56756;
        run_job(0, 25'd1966080);
        chk("lat_ack_to_vld",  last_vld_cyc - last_ack_cyc, 1);
        chk("lat_done_to_rsp", last_rsp_cyc - last_done_cyc, 2);

        run_job(1, 25'd13762560);                 // 210 deg
        pe_sin = 32'd0; pe_cos = Q16_ONE;
        run_job(2, D90);
        run_job(3, D270);
        pe_sin = 32'd100; pe_cos = 32'd200;
        run_job(0, D360 - 25'd1);
        v = vld_cnt;
        run_job(1, D360);
        chk("d360_no_pe_vld", vld_cnt, v);
        pe_sin = 32'd46341; pe_cos = 32'd46341;
        run_job(3, 25'd8847360);                  // 135 deg

        // pe_done while idle must be ignored
        b = rsp_cnt;
        @(posedge clk); #1 spur = 1;
        @(posedge clk); #1 spur = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("spur_no_rsp", rsp_cnt, b);
        chk("spur_not_busy", busy, 0);

        // all four requesting continuously
        pe_sin = 32'd32768; pe_cos = 32'd56756;
        req_angle[0*ANG_W +: ANG_W] = 25'd1966080;
        req_angle[1*ANG_W +: ANG_W] = 25'd7864320;
        req_angle[2*ANG_W +: ANG_W] = 25'd13762560;
        req_angle[3*ANG_W +: ANG_W] = 25'd19660800;
        a0 = ack_log.size();
        b  = rsp_cnt;
        hold_acks(4'b1111, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("rr_ack_count", ack_log.size() - a0, 5);
        chk("rr_rsp_count", rsp_cnt - b, 5);
        for (int k = 0; k < 5 && a0 + k < ack_log.size(); k++)
            chk($sformatf("rr_ack_order%0d", k), ack_log[a0 + k], k % 4);

        // engine never finishes
        eng_mute = 1;
        run_job(2, 25'd1966080);
        chk("timeout_latency", last_rsp_cyc - last_vld_cyc, TIMEOUT + 1);
        eng_mute = 0;
        run_job(2, 25'd1966080);

        // reset in the middle of WAIT
        eng_lat = 20;
        req_angle[0*ANG_W +: ANG_W] = 25'd1966080;
        @(posedge clk); #1 req[0] = 1'b1;
        got = 0;
        for (t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ack[0]) got = 1;
        end
        if (!got) chk("ack_wait_pre_rst", 0, 1);
        @(posedge clk); #1 req[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        eng_lat = 3;
        rst_n = 1'b1;
        a0 = ack_log.size();
        run_job(2, 25'd1966080);
        chk("post_rst_first_gnt", (ack_log.size() > a0) ? ack_log[a0] : -1, 2);

        // pointer returns to N-1 on reset: 0 beats 3
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        req_angle[3*ANG_W +: ANG_W] = 25'd19660800;
        a0 = ack_log.size();
        hold_acks(4'b1001, 2);
        chk("rst_ptr_gnt0", (ack_log.size() > a0)     ? ack_log[a0]     : -1, 0);
        chk("rst_ptr_gnt1", (ack_log.size() > a0 + 1) ? ack_log[a0 + 1] : -1, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("pe_angle_stable", ang_bad, 0);
        chk("ack_onehot", onehot_bad, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("pe_queue_empty", pe_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Round-robin scheduler that shares one sin/cos CORDIC engine between N requesters.
- The engine accepts angles 0..90 deg, scaled by 2^16.
- This block accepts full-circle angles (0..<360 deg, scaled by 2^16) and folds each one into the first quadrant.
- It sequences the engine's vld/done handshake, restores the quadrant signs, and returns tagged results.

Parameters:
- N, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; equals clog2(N).
- TIMEOUT, 32, maximum cycles to wait for engine done before an error response.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req  in  N  per-requester request, level; held until its ack
- req_angle  in  N*25  per-requester angle, unsigned deg*2^16; slice i = bits [25*i+24:25*i]
- req_ack  out  N  one-hot, one-cycle accept pulse
- rsp_vld  out  1  one-cycle result strobe
- rsp_id  out  ID_W  requester id of the result
- rsp_sin  out  32  signed sin, Q16
- rsp_cos  out  32  signed cos, Q16
- rsp_err  out  1  qualifies rsp_vld: angle out of range, or timeout
- busy  out  1  high in any state other than IDLE
- pe_vld  out  1  engine start pulse
- pe_angle  out  23  folded angle to the engine
- pe_sin  in  32  engine sin, signed
- pe_cos  in  32  engine cos, signed
- pe_done  in  1  engine completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; rr pointer = N-1, so requester 0 wins first.
- Reset mid-operation: abandon the job, send no response. The engine's own reset is shared.
- Constants: D90=5898240, D180=11796480, D270=17694720, D360=23592960.
- IDLE:
  - If req!=0, grant the first set bit searching upward from (rr+1) mod N, wrapping.
  - Pulse req_ack[g]; latch the angle and id; set rr=g.
  - Compute quadrant q and folded angle a' = angle - q*90deg.
  - If angle >= D360, go to RESP with err=1, sin=cos=0, and do not issue to the engine.
  - Otherwise go to ISSUE.
- ISSUE: pe_vld=1 for exactly one cycle. pe_angle=a' and stays constant from ISSUE until the job leaves WAIT (the engine reloads its angle every cycle). Then go to WAIT.
- WAIT:
  - A cycle counter starts at 0 on entry.
  - On pe_done=1, go to CAPT.
  - If the counter reaches TIMEOUT-1 without pe_done, go to RESP with err=1, sin=cos=0.
- CAPT:
  - pe_sin/pe_cos are sampled on the clock edge that ends CAPT, one cycle after pe_done.
  - Unfold, with (s,c) = engine outputs:
    - q0: sin=s, cos=c
    - q1: sin=c, cos=-s
    - q2: sin=-s, cos=-c
    - q3: sin=-c, cos=s
  - Negation is 32-bit two's complement.
- RESP: rsp_vld=1 for one cycle, with id/sin/cos/err valid. Output registers hold their values until the next RESP. Then return to IDLE.
- Throughput: one job in flight. A new grant is possible the cycle after RESP.
- Latency: req seen in IDLE -> ack same cycle -> pe_vld next cycle -> rsp_vld 2 cycles after pe_done.
- Simultaneous requests: exactly one ack per grant; losers keep req high and are served in rr order.
- A pe_done seen outside WAIT is ignored.
- A requester dropping req before ack is legal; it is simply not granted.
- Angle boundaries, with a' always in [0, D90):
  - angle = D90 -> q1, a'=0
  - angle = D270 -> q3, a'=0
  - angle = D360-1 -> q3

Decomposition:
- Package cordic_pkg: D90/D180/D270/D360, angle widths (25 in, 23 engine), Q16 one constant (65536), state encoding enum.
- One sub-module, cordic_rr_arb: N-way round-robin pointer plus one-hot grant, purely combinational grant with a registered pointer.
- Quadrant fold/unfold stays inline.

Test Plan:
- Single request, angle=30deg (1966080): engine model returns s=32768, c=56756 -> pe_angle=1966080, rsp_sin=32768, rsp_cos=56756, rsp_id=0, err=0.
- angle=210deg (13762560): pe_angle=1966080; model returns s=32768, c=56756 -> rsp_sin=-32768, rsp_cos=-56756.
- Boundaries:
  - angle=D90 -> pe_angle=0; model s=0, c=65536 -> rsp_sin=65536, rsp_cos=0.
  - angle=D360 -> rsp_err=1 with no pe_vld.
- All four req held high continuously -> acks in order 0,1,2,3,0; exactly one ack per job; pe_angle stable throughout every WAIT.
- Model never asserts pe_done -> rsp_vld with err=1 exactly TIMEOUT cycles after WAIT entry; the next request is then served normally.
- Assert rst_n low during WAIT -> all outputs 0 immediately; after release, req[2] alone is granted first.
